traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 The block SHALL have parameter P_MIN_GRN, default 8, meaning minimum green duration in clock cycles (legal range 1..255).
REQ-002 The block SHALL have parameter P_YEL, default 4, meaning yellow duration in clock cycles (legal range 1..255).
REQ-003 The block SHALL have parameter P_ALLRED, default 2, meaning all-red clearance duration in clock cycles (legal range 1..255).
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_rstn  input  1  asynchronous, active-low reset.
REQ-006 i_TA  input  1  traffic present on street A, synchronous to i_clk.
REQ-007 i_TB  input  1  traffic present on street B, synchronous to i_clk.
REQ-008 i_M  input  1  parade mode, driven by the mode FSM; 1 = hold street B green.
REQ-009 o_LA  output  2  street A light: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED.
REQ-010 o_LB  output  2  street B light, same encoding as o_LA.
REQ-011 o_state  output  3  current state code, for debug and verification.

Function
REQ-012 The FSM SHALL have six states: S_AG=0 (A green, B red), S_AY=1 (A yellow, B red), S_AR=2 (all red, after A), S_BG=3 (B green, A red), S_BY=4 (B yellow, A red), S_BR=5 (all red, after B); codes 6 and 7 SHALL go to S_AG on the next cycle.
REQ-013 A phase counter SHALL clear to 0 on every state change and increment by 1 each cycle otherwise, saturating at max(P_MIN_GRN,P_YEL,P_ALLRED)-1; its width SHALL be $clog2 of that maximum, minimum 1 bit.
REQ-014 S_AG -> S_AY SHALL occur when i_TA==0 and the counter >= P_MIN_GRN-1; otherwise the FSM SHALL stay in S_AG.
REQ-015 S_AY -> S_AR SHALL occur when the counter == P_YEL-1, so yellow lasts exactly P_YEL cycles.
REQ-016 S_AR -> S_BG SHALL occur when the counter == P_ALLRED-1.
REQ-017 S_BG -> S_BY SHALL occur when i_TB==0, i_M==0 and the counter >= P_MIN_GRN-1; while i_M==1 the FSM SHALL stay in S_BG regardless of i_TB.
REQ-018 S_BY -> S_BR SHALL occur after P_YEL cycles; S_BR -> S_AG SHALL occur after P_ALLRED cycles.
REQ-019 i_M SHALL NOT affect S_AG, S_AY, S_AR, S_BY or S_BR; raising i_M during S_AG SHALL let A finish its normal sequence, after which B is held green.
REQ-020 A sensor deasserted after the minimum-green time SHALL leave green on the next rising edge, so the light turns yellow one cycle later.
REQ-021 Sensor pulses shorter than the remaining minimum-green time SHALL have no effect.
REQ-022 o_LA, o_LB and o_state SHALL be a combinational Moore decode of the state register only, with no combinational path from any input.
REQ-023 At no time SHALL o_LA and o_LB both be non-RED.

Reset
REQ-024 When i_rstn==0, the state SHALL be S_AG, the counter 0, o_LA=GREEN, o_LB=RED and o_state=0, immediately and without a clock edge.
REQ-025 Reset asserted mid-phase SHALL abort that phase; after release the minimum-green count SHALL restart from 0 on the first rising edge.

Structure
REQ-026 State codes, light encodings and the duration defaults SHALL live in a shared package, traffic_light_pkg, which is also used by the mode FSM bench.
REQ-027 The phase counter SHALL be one sub-module, phase_timer, with inputs clear and enable and a count output; the FSM SHALL be in the top module.

Verification
REQ-028 Hold i_TA=0, i_TB=1, i_M=0 after reset -> A green 8 cycles, A yellow 4, all red 2, then B green held for as long as i_TB=1.
REQ-029 Hold i_TA=1 for 20 cycles, then drop it to 0 -> o_LA=GREEN throughout the 20 cycles, and o_LA=YELLOW one cycle after the drop.
REQ-030 In S_BG, set i_M=1 and i_TB=0 for 30 cycles -> o_LB stays GREEN; drop i_M -> o_LB=YELLOW one cycle later.
REQ-031 Pulse i_TA=1 for 2 cycles at counter=3 in S_AG -> the S_AY transition still occurs at cycle 8.
REQ-032 Assert i_rstn=0 in S_BY -> o_LA=GREEN and o_LB=RED asynchronously, with o_state=0.
REQ-033 Run 10k random cycles of i_TA/i_TB/i_M -> assertions for REQ-023 and every phase length hold, and o_state never reads 6 or 7.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared state codes, light encodings and duration defaults for the
// intersection controller and its mode-FSM bench.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    S_AG = 3'd0,
    S_AY = 3'd1,
    S_AR = 3'd2,
    S_BG = 3'd3,
    S_BY = 3'd4,
    S_BR = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    L_GRN = 2'b00,
    L_YEL = 2'b01,
    L_RED = 2'b10
  } light_e;

  localparam int unsigned D_MIN_GRN = 8;
  localparam int unsigned D_YEL     = 4;
  localparam int unsigned D_ALLRED  = 2;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Sensor/mode inputs and light/debug outputs of the controller.
// master drives sensors and mode; slave drives lights and state.
interface traffic_light_ctrl_if;
  logic       TA;
  logic       TB;
  logic       M;
  logic [1:0] LA;
  logic [1:0] LB;
  logic [2:0] state;

  modport master (
    output TA, TB, M,
    input  LA, LB, state
  );

  modport slave (
    input  TA, TB, M,
    output LA, LB, state
  );
endinterface

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Phase counter: clear wins, else counts up while enabled, saturating.
// Ports: i_clk, i_rstn, i_clr, i_en in; o_cnt count out.
module phase_timer #(
  parameter int unsigned     P_W   = 3,
  parameter logic [P_W-1:0]  P_SAT = '1
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_clr,
  input  logic           i_en,
  output logic [P_W-1:0] o_cnt
);

  logic [P_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != P_SAT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-street traffic light FSM with sensors and parade hold on B.
// Ports: i_clk, i_rstn, i_TA, i_TB, i_M in; o_LA, o_LB, o_state out.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int unsigned P_MIN_GRN = D_MIN_GRN,
  parameter int unsigned P_YEL     = D_YEL,
  parameter int unsigned P_ALLRED  = D_ALLRED
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_TA,
  input  logic       i_TB,
  input  logic       i_M,
  output logic [1:0] o_LA,
  output logic [1:0] o_LB,
  output logic [2:0] o_state
);

  localparam int unsigned LP_MAX =
    max3(P_MIN_GRN, P_YEL, P_ALLRED);
  localparam int unsigned LP_W =
    (LP_MAX > 1) ? $clog2(LP_MAX) : 1;

  localparam logic [LP_W-1:0] LP_SAT =
    LP_W'(LP_MAX - 1);
  localparam logic [LP_W-1:0] LP_GRN_END =
    LP_W'(P_MIN_GRN - 1);
  localparam logic [LP_W-1:0] LP_YEL_END =
    LP_W'(P_YEL - 1);
  localparam logic [LP_W-1:0] LP_AR_END =
    LP_W'(P_ALLRED - 1);

  state_e          r_state;
  state_e          w_next;
  logic [LP_W-1:0] w_cnt;
  logic            w_clr;
  logic            w_en;

  // Counter restarts whenever the state is about to change.
  assign w_clr = (w_next != r_state);
  assign w_en  = 1'b1;

  phase_timer #(
    .P_W   (LP_W),
    .P_SAT (LP_SAT)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_cnt  (w_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_AG;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_AG:
        if (!i_TA && (w_cnt >= LP_GRN_END))
          w_next = S_AY;
      S_AY:
        if (w_cnt == LP_YEL_END)
          w_next = S_AR;
      S_AR:
        if (w_cnt == LP_AR_END)
          w_next = S_BG;
      S_BG:
        if (!i_TB && !i_M && (w_cnt >= LP_GRN_END))
          w_next = S_BY;
      S_BY:
        if (w_cnt == LP_YEL_END)
          w_next = S_BR;
      S_BR:
        if (w_cnt == LP_AR_END)
          w_next = S_AG;
      default:
        w_next = S_AG;
    endcase
  end

  // Undefined codes show all red for the one cycle they can exist.
  always_comb begin
    o_LA = L_RED;
    o_LB = L_RED;
    unique case (r_state)
      S_AG:    o_LA = L_GRN;
      S_AY:    o_LA = L_YEL;
      S_BG:    o_LB = L_GRN;
      S_BY:    o_LB = L_YEL;
      default: ;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and random bench for traffic_light_ctrl with default timing.
// Immediate assertions at each check; one summary line at the end.
module tb_traffic_light_ctrl;
  import traffic_light_pkg::*;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  traffic_light_ctrl_if tl ();

  traffic_light_ctrl dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_TA    (tl.TA),
    .i_TB    (tl.TB),
    .i_M     (tl.M),
    .o_LA    (tl.LA),
    .o_LB    (tl.LB),
    .o_state (tl.state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input state_e s);
    chk(tag, 32'(tl.state), 32'(s));
  endtask

  // Phase-length and safety monitor, sampled on the falling edge.
  int     mon_len;
  state_e mon_prev;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_len  = 0;
      mon_prev = S_AG;
    end else begin
      chk("both_not_red",
          32'((tl.LA == L_RED) || (tl.LB == L_RED)), 32'd1);
      chk("state_legal", 32'(tl.state < 3'd6), 32'd1);
      if (tl.state != 3'(mon_prev)) begin
        case (mon_prev)
          S_AG, S_BG:
            chk("green_len", 32'(mon_len >= 8), 32'd1);
          S_AY, S_BY:
            chk("yel_len", 32'(mon_len), 32'd4);
          S_AR, S_BR:
            chk("allred_len", 32'(mon_len), 32'd2);
          default: ;
        endcase
        mon_len  = 1;
        mon_prev = state_e'(tl.state);
      end else begin
        mon_len++;
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn  = 1'b0;
    tl.TA = 1'b0;
    tl.TB = 1'b1;
    tl.M  = 1'b0;
    #3;
    chk("rst_LA", 32'(tl.LA), 32'(L_GRN));
    chk("rst_LB", 32'(tl.LB), 32'(L_RED));
    chk("rst_state", 32'(tl.state), 32'd0);
    step(2);
    rstn = 1'b1;

    // Basic cycle: 8 green, 4 yellow, 2 all red, B held.
    for (int i = 0; i < 8; i++) begin
      chk_st("seq_AG", S_AG);
      chk("seq_LA_grn", 32'(tl.LA), 32'(L_GRN));
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      chk_st("seq_AY", S_AY);
      chk("seq_LA_yel", 32'(tl.LA), 32'(L_YEL));
      step(1);
    end
    for (int i = 0; i < 2; i++) begin
      chk_st("seq_AR", S_AR);
      step(1);
    end
    for (int i = 0; i < 12; i++) begin
      chk("seq_LB_grn", 32'(tl.LB), 32'(L_GRN));
      step(1);
    end

    // Parade hold on B regardless of sensor.
    tl.M  = 1'b1;
    tl.TB = 1'b0;
    for (int i = 0; i < 30; i++) begin
      chk("par_LB_grn", 32'(tl.LB), 32'(L_GRN));
      step(1);
    end
    tl.M = 1'b0;
    step(1);
    chk("par_LB_yel", 32'(tl.LB), 32'(L_YEL));

    // Asynchronous reset in B yellow.
    step(2);
    chk_st("pre_rst_BY", S_BY);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_LA", 32'(tl.LA), 32'(L_GRN));
    chk("arst_LB", 32'(tl.LB), 32'(L_RED));
    chk("arst_state", 32'(tl.state), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // A sensor held 20 cycles then dropped.
    tl.TA = 1'b1;
    tl.TB = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("ta_LA_grn", 32'(tl.LA), 32'(L_GRN));
      step(1);
    end
    tl.TA = 1'b0;
    step(1);
    chk("ta_LA_yel", 32'(tl.LA), 32'(L_YEL));
    step(4);
    chk_st("ta_AR", S_AR);
    step(2);
    chk_st("ta_BG", S_BG);

    // B leaves after minimum green, back round to A.
    tl.TB = 1'b0;
    step(7);
    chk_st("bg_last", S_BG);
    step(1);
    chk_st("bg_to_BY", S_BY);
    step(4);
    chk_st("by_to_BR", S_BR);
    step(2);
    chk_st("br_to_AG", S_AG);

    // Short sensor pulse inside minimum green is ignored.
    step(3);
    tl.TA = 1'b1;
    step(2);
    tl.TA = 1'b0;
    step(2);
    chk_st("pulse_AG7", S_AG);
    step(1);
    chk_st("pulse_AY", S_AY);

    // Random sensor/mode activity under the monitor.
    for (int i = 0; i < 10000; i++) begin
      tl.TA = 1'($urandom_range(0, 1));
      tl.TB = 1'($urandom_range(0, 1));
      tl.M  = ($urandom_range(0, 7) == 0);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
